// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into IWIDTH-bit words written to sequential addresses from 0.
// Latency: write strobe one cycle after the last byte of a word; BYTES+1 cycles per word with valid held high.
// Backpressure: ready is high only while receiving; bytes offered during the write cycle, DONE, ERR or IDLE wait.
module imem_loader #(
    parameter int IWIDTH = 32,
    parameter int DEPTH  = 6
) (
    input  logic              l_clk,
    input  logic              l_rst,
    input  logic              l_i_start,
    input  logic [DEPTH:0]    l_i_len,
    input  logic              l_i_valid,
    input  logic [7:0]        l_i_byte,
    output logic              l_o_ready,
    output logic              l_o_we,
    output logic [DEPTH-1:0]  l_o_addr,
    output logic [IWIDTH-1:0] l_o_wdata,
    output logic              l_o_busy,
    output logic              l_o_done,
    output logic              l_o_cpu_ce,
    output logic              l_o_err
);

    localparam int BYTES = IWIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    // Largest legal load length: the whole memory.
    localparam logic [DEPTH:0]  CAP       = (DEPTH + 1)'(1) << DEPTH;
    localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BYTES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]        state_q,    state_d;
    logic [DEPTH:0]    len_q,      len_d;
    logic [DEPTH:0]    word_cnt_q, word_cnt_d;
    logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [DEPTH-1:0]  addr_q,     addr_d;
    logic [IWIDTH-1:0] shreg_q,    shreg_d;
    logic [IWIDTH-1:0] wdata_q,    wdata_d;
    logic              start_ok;

    // Next-state and datapath updates for the load sequencer.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        shreg_d    = shreg_q;
        wdata_d    = wdata_q;
        start_ok   = l_i_start &&
                     ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_ok) begin
                    len_d      = l_i_len;
                    addr_d     = '0;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    shreg_d    = '0;
                    if (l_i_len > CAP) begin
                        state_d = S_ERR;
                    end else if (l_i_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RECV;
                    end
                end
            end
            S_RECV: begin
                // ready is 1 here, so valid alone completes the handshake.
                if (l_i_valid) begin
                    shreg_d = (shreg_q << 8) | IWIDTH'(l_i_byte);
                    if (byte_cnt_q == LAST_BYTE) begin
                        wdata_d    = shreg_d;
                        byte_cnt_d = '0;
                        state_d    = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
            end
            S_WRITE: begin
                if (word_cnt_q == (len_q - (DEPTH + 1)'(1))) begin
                    state_d = S_DONE;
                end else begin
                    // len never exceeds CAP, so addr stops at 2**DEPTH-1 without wrapping.
                    addr_d     = addr_q + DEPTH'(1);
                    word_cnt_d = word_cnt_q + (DEPTH + 1)'(1);
                    state_d    = S_RECV;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any load in flight.
    always_ff @(posedge l_clk or negedge l_rst) begin
        if (!l_rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            shreg_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            shreg_q    <= shreg_d;
            wdata_q    <= wdata_d;
        end
    end

    // Control outputs decode straight from the state register.
    assign l_o_ready  = (state_q == S_RECV);
    assign l_o_we     = (state_q == S_WRITE);
    assign l_o_busy   = (state_q == S_RECV) || (state_q == S_WRITE);
    assign l_o_done   = (state_q == S_DONE);
    assign l_o_cpu_ce = (state_q == S_DONE);
    assign l_o_err    = (state_q == S_ERR);
    assign l_o_addr   = addr_q;
    assign l_o_wdata  = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives and samples on the falling clock edge.
// Write strobes are captured into queues with the cycle number they appeared on.
// Each scenario task checks its own expectations inline.
module tb_imem_loader;

    localparam int IW = 32;
    localparam int DP = 6;

    logic          l_clk     = 1'b0;
    logic          l_rst     = 1'b0;
    logic          l_i_start = 1'b0;
    logic [DP:0]   l_i_len   = '0;
    logic          l_i_valid = 1'b0;
    logic [7:0]    l_i_byte  = '0;
    logic          l_o_ready, l_o_we, l_o_busy, l_o_done, l_o_cpu_ce, l_o_err;
    logic [DP-1:0] l_o_addr;
    logic [IW-1:0] l_o_wdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [DP-1:0] wa[$];
    logic [IW-1:0] wd[$];
    int            wc[$];

    // flag order: ready, we, busy, done, cpu_ce, err
    wire [5:0] flags = {l_o_ready, l_o_we, l_o_busy, l_o_done, l_o_cpu_ce, l_o_err};
    localparam logic [5:0] F_IDLE  = 6'b000000;
    localparam logic [5:0] F_RECV  = 6'b101000;
    localparam logic [5:0] F_WRITE = 6'b011000;
    localparam logic [5:0] F_DONE  = 6'b000110;
    localparam logic [5:0] F_ERR   = 6'b000001;

    imem_loader #(.IWIDTH(IW), .DEPTH(DP)) dut (
        .l_clk      (l_clk),
        .l_rst      (l_rst),
        .l_i_start  (l_i_start),
        .l_i_len    (l_i_len),
        .l_i_valid  (l_i_valid),
        .l_i_byte   (l_i_byte),
        .l_o_ready  (l_o_ready),
        .l_o_we     (l_o_we),
        .l_o_addr   (l_o_addr),
        .l_o_wdata  (l_o_wdata),
        .l_o_busy   (l_o_busy),
        .l_o_done   (l_o_done),
        .l_o_cpu_ce (l_o_cpu_ce),
        .l_o_err    (l_o_err)
    );

    always #5 l_clk = ~l_clk;

    always @(posedge l_clk) cyc <= cyc + 1;

    always @(negedge l_clk) begin
        if (l_o_we === 1'b1) begin
            wa.push_back(l_o_addr);
            wd.push_back(l_o_wdata);
            wc.push_back(cyc);
        end
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic do_start(input logic [DP:0] len);
        @(negedge l_clk);
        l_i_start = 1'b1;
        l_i_len   = len;
        @(negedge l_clk);
        l_i_start = 1'b0;
    endtask

    // Offer one byte; returns on the falling edge after it was taken (valid left high).
    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok        = 1'b0;
        l_i_valid = 1'b1;
        l_i_byte  = b;
        for (int n = 0; n < 40; n++) begin
            if (l_o_ready === 1'b1) begin
                ok = 1'b1;
                @(negedge l_clk);
                break;
            end
            @(negedge l_clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, output bit ok);
        bit b_ok;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_byte(w[31-8*k -: 8], b_ok);
            ok &= b_ok;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (l_o_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge l_clk);
        end
    endtask

    task automatic test_reset();
        l_rst = 1'b0;
        #12;
        n_cmp++; if (flags !== F_IDLE) begin n_bad++; $display("FAIL reset_flags: got %b expected %b", flags, F_IDLE); end
        n_cmp++; if (l_o_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %0h expected 0", l_o_addr); end
        n_cmp++; if (l_o_wdata !== '0) begin n_bad++; $display("FAIL reset_wdata: got %0h expected 0", l_o_wdata); end
        @(negedge l_clk);
        l_rst = 1'b1;
        repeat (2) @(negedge l_clk);
        n_cmp++; if (flags !== F_IDLE) begin n_bad++; $display("FAIL idle_flags: got %b expected %b", flags, F_IDLE); end
    endtask

    task automatic test_len0();
        clear_log();
        do_start(7'd0);
        n_cmp++; if (flags !== F_DONE) begin n_bad++; $display("FAIL len0_flags: got %b expected %b", flags, F_DONE); end
        repeat (3) @(negedge l_clk);
        n_cmp++; if (wa.size() != 0) begin n_bad++; $display("FAIL len0_writes: got %0d expected 0", wa.size()); end
    endtask

    task automatic test_stream();
        bit ok, all;
        all = 1'b1;
        clear_log();
        do_start(7'd2);
        n_cmp++; if (flags !== F_RECV) begin n_bad++; $display("FAIL stream_recv: got %b expected %b", flags, F_RECV); end
        send_word(32'h20080005, ok); all &= ok;
        send_word(32'h3C011234, ok); all &= ok;
        l_i_valid = 1'b0;
        wait_done(ok); all &= ok;
        n_cmp++; if (!all) begin n_bad++; $display("FAIL stream_timeout: got 0 expected 1"); end
        n_cmp++; if (wa.size() != 2) begin n_bad++; $display("FAIL stream_count: got %0d expected 2", wa.size()); end
        if (wa.size() == 2) begin
            n_cmp++; if (wa[0] !== 6'd0) begin n_bad++; $display("FAIL stream_addr0: got %0h expected 0", wa[0]); end
            n_cmp++; if (wa[1] !== 6'd1) begin n_bad++; $display("FAIL stream_addr1: got %0h expected 1", wa[1]); end
            n_cmp++; if (wd[0] !== 32'h20080005) begin n_bad++; $display("FAIL stream_data0: got %0h expected 20080005", wd[0]); end
            n_cmp++; if (wd[1] !== 32'h3C011234) begin n_bad++; $display("FAIL stream_data1: got %0h expected 3c011234", wd[1]); end
            n_cmp++; if (wc[1] - wc[0] != 5) begin n_bad++; $display("FAIL stream_spacing: got %0d expected 5", wc[1] - wc[0]); end
        end
        n_cmp++; if (flags !== F_DONE) begin n_bad++; $display("FAIL stream_done: got %b expected %b", flags, F_DONE); end
    endtask

    task automatic test_gaps();
        logic [31:0] words [2];
        logic [5:0]  exp;
        bit ok, all;
        int gap_bad;
        words[0] = 32'h20080005;
        words[1] = 32'h3C011234;
        all = 1'b1;
        gap_bad = 0;
        clear_log();
        do_start(7'd2);
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(words[w][31-8*k -: 8], ok); all &= ok;
                l_i_valid = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    exp = (k == 3) ? F_WRITE : F_RECV;
                    if ((k != 3 || g == 0) && flags !== exp) begin
                        gap_bad++;
                        $display("note gap w%0d k%0d g%0d flags=%b", w, k, g, flags);
                    end
                    @(negedge l_clk);
                end
            end
        end
        wait_done(ok); all &= ok;
        n_cmp++; if (!all) begin n_bad++; $display("FAIL gaps_timeout: got 0 expected 1"); end
        n_cmp++; if (gap_bad != 0) begin n_bad++; $display("FAIL gaps_flags: got %0d bad cycles expected 0", gap_bad); end
        n_cmp++; if (wa.size() != 2) begin n_bad++; $display("FAIL gaps_count: got %0d expected 2", wa.size()); end
        if (wa.size() == 2) begin
            n_cmp++; if (wa[1] !== 6'd1) begin n_bad++; $display("FAIL gaps_addr1: got %0h expected 1", wa[1]); end
            n_cmp++; if (wd[0] !== 32'h20080005) begin n_bad++; $display("FAIL gaps_data0: got %0h expected 20080005", wd[0]); end
            n_cmp++; if (wd[1] !== 32'h3C011234) begin n_bad++; $display("FAIL gaps_data1: got %0h expected 3c011234", wd[1]); end
        end
    endtask

    task automatic test_err();
        bit ok, all;
        all = 1'b1;
        clear_log();
        do_start(7'd65);
        n_cmp++; if (flags !== F_ERR) begin n_bad++; $display("FAIL err_flags: got %b expected %b", flags, F_ERR); end
        l_i_valid = 1'b1;
        l_i_byte  = 8'h55;
        repeat (4) @(negedge l_clk);
        l_i_valid = 1'b0;
        n_cmp++; if (flags !== F_ERR) begin n_bad++; $display("FAIL err_hold: got %b expected %b", flags, F_ERR); end
        n_cmp++; if (wa.size() != 0) begin n_bad++; $display("FAIL err_writes: got %0d expected 0", wa.size()); end
        do_start(7'd1);
        n_cmp++; if (flags !== F_RECV) begin n_bad++; $display("FAIL err_exit: got %b expected %b", flags, F_RECV); end
        send_word(32'h00000000, ok); all &= ok;
        l_i_valid = 1'b0;
        wait_done(ok); all &= ok;
        n_cmp++; if (!all) begin n_bad++; $display("FAIL err_timeout: got 0 expected 1"); end
        n_cmp++; if (wa.size() != 1) begin n_bad++; $display("FAIL err_reload_count: got %0d expected 1", wa.size()); end
        if (wa.size() == 1) begin
            n_cmp++; if (wa[0] !== 6'd0 || wd[0] !== 32'h0) begin n_bad++; $display("FAIL err_reload_word: got %0h@%0h expected 0@0", wd[0], wa[0]); end
        end
    endtask

    task automatic test_abort();
        bit ok, all;
        all = 1'b1;
        clear_log();
        do_start(7'd1);
        send_byte(8'h11, ok); all &= ok;
        send_byte(8'h22, ok); all &= ok;
        l_i_valid = 1'b0;
        #2;
        l_rst = 1'b0;
        #1;
        n_cmp++; if (flags !== F_IDLE) begin n_bad++; $display("FAIL abort_flags: got %b expected %b", flags, F_IDLE); end
        repeat (3) @(negedge l_clk);
        l_rst = 1'b1;
        n_cmp++; if (wa.size() != 0) begin n_bad++; $display("FAIL abort_writes: got %0d expected 0", wa.size()); end
        do_start(7'd1);
        send_word(32'hAABBCCDD, ok); all &= ok;
        l_i_valid = 1'b0;
        wait_done(ok); all &= ok;
        n_cmp++; if (!all) begin n_bad++; $display("FAIL abort_timeout: got 0 expected 1"); end
        n_cmp++; if (wa.size() != 1) begin n_bad++; $display("FAIL abort_count: got %0d expected 1", wa.size()); end
        if (wa.size() == 1) begin
            n_cmp++; if (wa[0] !== 6'd0 || wd[0] !== 32'hAABBCCDD) begin n_bad++; $display("FAIL abort_word: got %0h@%0h expected aabbccdd@0", wd[0], wa[0]); end
        end
    endtask

    task automatic test_restart();
        bit ok, all;
        all = 1'b1;
        clear_log();
        do_start(7'd3);
        send_word(32'h01020304, ok); all &= ok;
        send_byte(8'h05, ok); all &= ok;
        l_i_valid = 1'b0;
        l_i_start = 1'b1;
        l_i_len   = 7'd1;
        @(negedge l_clk);
        l_i_start = 1'b0;
        n_cmp++; if (flags !== F_RECV) begin n_bad++; $display("FAIL ignore_flags: got %b expected %b", flags, F_RECV); end
        n_cmp++; if (l_o_addr !== 6'd1) begin n_bad++; $display("FAIL ignore_addr: got %0h expected 1", l_o_addr); end
        send_byte(8'h06, ok); all &= ok;
        send_byte(8'h07, ok); all &= ok;
        send_byte(8'h08, ok); all &= ok;
        send_word(32'h090A0B0C, ok); all &= ok;
        l_i_valid = 1'b0;
        wait_done(ok); all &= ok;
        n_cmp++; if (wa.size() != 3) begin n_bad++; $display("FAIL ignore_count: got %0d expected 3", wa.size()); end
        if (wa.size() == 3) begin
            n_cmp++; if (wd[1] !== 32'h05060708) begin n_bad++; $display("FAIL ignore_data1: got %0h expected 05060708", wd[1]); end
            n_cmp++; if (wa[2] !== 6'd2 || wd[2] !== 32'h090A0B0C) begin n_bad++; $display("FAIL ignore_word2: got %0h@%0h expected 090a0b0c@2", wd[2], wa[2]); end
        end
        l_i_start = 1'b1;
        l_i_len   = 7'd1;
        @(negedge l_clk);
        l_i_start = 1'b0;
        n_cmp++; if (flags !== F_RECV) begin n_bad++; $display("FAIL restart_flags: got %b expected %b", flags, F_RECV); end
        n_cmp++; if (l_o_addr !== 6'd0) begin n_bad++; $display("FAIL restart_addr: got %0h expected 0", l_o_addr); end
        clear_log();
        send_word(32'hDEADBEEF, ok); all &= ok;
        l_i_valid = 1'b0;
        wait_done(ok); all &= ok;
        n_cmp++; if (!all) begin n_bad++; $display("FAIL restart_timeout: got 0 expected 1"); end
        n_cmp++; if (wa.size() != 1) begin n_bad++; $display("FAIL restart_count: got %0d expected 1", wa.size()); end
        if (wa.size() == 1) begin
            n_cmp++; if (wa[0] !== 6'd0 || wd[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL restart_word: got %0h@%0h expected deadbeef@0", wd[0], wa[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_len0();
        test_stream();
        test_gaps();
        test_err();
        test_abort();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
